// File: rtl/rob_cmpl_arbiter.sv
// rob_cmpl_arbiter
//   Collects completion records (ROB index, mispredict flag, corrected PC)
//   from NREQ execution units into per-unit 2-entry FIFOs and grants up to
//   two records per cycle, round-robin, onto two registered ROB completion
//   ports.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset (also acts as flush)
//   Flush             synchronous pipeline flush; drops all buffered records
//   Req_V[i]          unit i presents a record this cycle
//   Req_Index         packed per-unit ROB index, slice i = unit i
//   Req_Mispred[i]    unit i mispredict flag
//   Req_NewPC         packed per-unit corrected PC, slice i = unit i
//   Req_Ready[i]      FIFO i accepts this cycle (not credited by same-cycle pop)
//   Out1_*, Out2_*    registered completion ports (valid, index, mispred, PC)
module rob_cmpl_arbiter #(
  parameter int NREQ           = 4,
  parameter int ROB_INDEX_SIZE = 7,
  parameter int PC_W           = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           Flush,
  input  logic [NREQ-1:0]                Req_V,
  input  logic [NREQ*ROB_INDEX_SIZE-1:0] Req_Index,
  input  logic [NREQ-1:0]                Req_Mispred,
  input  logic [NREQ*PC_W-1:0]           Req_NewPC,
  output logic [NREQ-1:0]                Req_Ready,
  output logic                           Out1_valid,
  output logic [ROB_INDEX_SIZE-1:0]      Out1_index,
  output logic                           Out1_mispred,
  output logic [PC_W-1:0]                Out1_new_PC,
  output logic                           Out2_valid,
  output logic [ROB_INDEX_SIZE-1:0]      Out2_index,
  output logic                           Out2_mispred,
  output logic [PC_W-1:0]                Out2_new_PC
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int REC_W = ROB_INDEX_SIZE + 1 + PC_W;
  localparam logic [PTR_W-1:0] LAST_UNIT = PTR_W'(NREQ - 1);

  // Record layout: {index, mispred, new_PC}
  logic [REC_W-1:0] head_rec [NREQ];
  logic [NREQ-1:0]  nonempty;
  logic [NREQ-1:0]  push;
  logic [NREQ-1:0]  pop;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] a_idx;
  logic [PTR_W-1:0] b_idx;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] last_idx;
  logic [PTR_W-1:0] rr_next;
  logic             a_found;
  logic             b_found;
  logic [REC_W-1:0] a_rec;
  logic [REC_W-1:0] b_rec;

  // ---------------------------------------------------------------------
  // Per-unit 2-entry FIFOs. head is always the oldest entry; tail is only
  // meaningful at count 2.
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NREQ; g++) begin : g_unit
    logic [1:0]       cnt;
    logic [REC_W-1:0] head;
    logic [REC_W-1:0] tail;
    logic [REC_W-1:0] in_rec;

    assign in_rec = {Req_Index[g*ROB_INDEX_SIZE +: ROB_INDEX_SIZE],
                     Req_Mispred[g],
                     Req_NewPC[g*PC_W +: PC_W]};

    // A full FIFO stays not-ready even when popped this cycle.
    assign Req_Ready[g]  = (cnt != 2'd2) && !Flush && !RST;
    assign push[g]       = Req_V[g] && Req_Ready[g];
    assign nonempty[g]   = (cnt != 2'd0);
    assign head_rec[g]   = head;

    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt  <= '0;
        head <= '0;
        tail <= '0;
      end else if (Flush) begin
        cnt <= '0;
      end else begin
        case ({push[g], pop[g]})
          2'b10: begin
            if (cnt == 2'd0) head <= in_rec;
            else             tail <= in_rec;
            cnt <= cnt + 2'd1;
          end
          2'b01: begin
            head <= tail;
            cnt  <= cnt - 2'd1;
          end
          // Only reachable at count 1: old head leaves, new record replaces it.
          2'b11: head <= in_rec;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin pick of up to two distinct non-empty FIFOs, scanning from
  // rr_ptr. Uses FIFO state at cycle start only.
  // ---------------------------------------------------------------------
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    sel     = '0;
    pop     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sel = PTR_W'((32'(rr_ptr) + k) % NREQ);
      if (nonempty[sel]) begin
        if (!a_found) begin
          a_found  = 1'b1;
          a_idx    = sel;
          pop[sel] = 1'b1;
        end else if (!b_found) begin
          b_found  = 1'b1;
          b_idx    = sel;
          pop[sel] = 1'b1;
        end
      end
    end
  end

  assign a_rec    = head_rec[a_idx];
  assign b_rec    = head_rec[b_idx];
  assign last_idx = b_found ? b_idx : a_idx;
  assign rr_next  = (last_idx == LAST_UNIT) ? '0 : last_idx + PTR_W'(1);

  // ---------------------------------------------------------------------
  // Registered completion ports and round-robin pointer. Port data holds
  // its last value when the port is not valid.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr       <= '0;
      Out1_valid   <= 1'b0;
      Out1_index   <= '0;
      Out1_mispred <= 1'b0;
      Out1_new_PC  <= '0;
      Out2_valid   <= 1'b0;
      Out2_index   <= '0;
      Out2_mispred <= 1'b0;
      Out2_new_PC  <= '0;
    end else if (Flush) begin
      rr_ptr     <= '0;
      Out1_valid <= 1'b0;
      Out2_valid <= 1'b0;
    end else begin
      Out1_valid <= a_found;
      Out2_valid <= b_found;
      if (a_found) begin
        {Out1_index, Out1_mispred, Out1_new_PC} <= a_rec;
        rr_ptr <= rr_next;
      end
      if (b_found) begin
        {Out2_index, Out2_mispred, Out2_new_PC} <= b_rec;
      end
    end
  end

endmodule

// File: tb/tb_rob_cmpl_arbiter.sv
// Directed self-checking bench for rob_cmpl_arbiter (NREQ=4, index 7b, PC 16b).
module tb_rob_cmpl_arbiter;

  logic        CLK;
  logic        RST;
  logic        Flush;
  logic [3:0]  Req_V;
  logic [27:0] Req_Index;
  logic [3:0]  Req_Mispred;
  logic [63:0] Req_NewPC;
  logic [3:0]  Req_Ready;
  logic        Out1_valid, Out2_valid;
  logic [6:0]  Out1_index, Out2_index;
  logic        Out1_mispred, Out2_mispred;
  logic [15:0] Out1_new_PC, Out2_new_PC;

  int compared;
  int mismatched;
  int seq [4];

  // Expected grant schedule for the saturated scenario (-1 = no grant)
  int       eu1 [9] = '{-1, 0, 2, 0, 2, 0, 2, 0, -1};
  int       eu2 [9] = '{-1, 1, 3, 1, 3, 1, 3, 1, -1};
  int       en  [9] = '{ 0, 0, 0, 1, 1, 2, 2, 3,  0};
  logic [3:0] erdy [5] = '{4'b1111, 4'b1111, 4'b0011, 4'b1100, 4'b0011};

  rob_cmpl_arbiter #(.NREQ(4), .ROB_INDEX_SIZE(7), .PC_W(16)) dut (
    .CLK(CLK), .RST(RST), .Flush(Flush),
    .Req_V(Req_V), .Req_Index(Req_Index), .Req_Mispred(Req_Mispred),
    .Req_NewPC(Req_NewPC), .Req_Ready(Req_Ready),
    .Out1_valid(Out1_valid), .Out1_index(Out1_index),
    .Out1_mispred(Out1_mispred), .Out1_new_PC(Out1_new_PC),
    .Out2_valid(Out2_valid), .Out2_index(Out2_index),
    .Out2_mispred(Out2_mispred), .Out2_new_PC(Out2_new_PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected valid record for unit u, sequence number n
  function automatic logic [24:0] erec(input int u, input int n);
    erec = {1'b1, 7'(u*16 + n), 1'((u + n) % 2), 16'(32'hA000 + u*256 + n)};
  endfunction

  function automatic logic [24:0] got1();
    got1 = {Out1_valid, Out1_index, Out1_mispred, Out1_new_PC};
  endfunction

  function automatic logic [24:0] got2();
    got2 = {Out2_valid, Out2_index, Out2_mispred, Out2_new_PC};
  endfunction

  task automatic apply(input logic [3:0] v);
    Req_V = v;
    for (int u = 0; u < 4; u++) begin
      Req_Index[u*7 +: 7]   = 7'(u*16 + seq[u]);
      Req_Mispred[u]        = 1'((u + seq[u]) % 2);
      Req_NewPC[u*16 +: 16] = 16'(32'hA000 + u*256 + seq[u]);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; Flush = 1'b0;
    for (int u = 0; u < 4; u++) seq[u] = 0;
    apply(4'hF);
    #1;
    compared++;
    if (Req_Ready !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_ready: got %b expected %b", Req_Ready, 4'b0000);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      compared++;
      if (got1() !== 25'd0 || got2() !== 25'd0) begin
        mismatched++;
        $display("FAIL reset_outputs: got %h/%h expected 0/0", got1(), got2());
      end
    end
    RST = 1'b0;
    apply(4'h0);
    #1;
    compared++;
    if (Req_Ready !== 4'b1111) begin
      mismatched++;
      $display("FAIL post_reset_ready: got %b expected %b", Req_Ready, 4'b1111);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      compared++;
      if (got1() !== 25'd0 || got2() !== 25'd0) begin
        mismatched++;
        $display("FAIL idle_outputs: got %h/%h expected 0/0", got1(), got2());
      end
    end
  endtask

  task automatic test_single();
    apply(4'b0100);
    Req_Index[14 +: 7]  = 7'h15;
    Req_Mispred[2]      = 1'b1;
    Req_NewPC[32 +: 16] = 16'h1234;
    tick();
    compared++;
    if (Out1_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL single_edge0_valid: got %b expected 0", Out1_valid);
    end
    apply(4'h0);
    tick();
    compared++;
    if (got1() !== {1'b1, 7'h15, 1'b1, 16'h1234}) begin
      mismatched++;
      $display("FAIL single_out1: got %h expected %h", got1(), {1'b1, 7'h15, 1'b1, 16'h1234});
    end
    compared++;
    if (Out2_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL single_out2_valid: got %b expected 0", Out2_valid);
    end
    tick();
    compared++;
    if ({Out1_valid, Out2_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL single_edge2_valid: got %b expected 00", {Out1_valid, Out2_valid});
    end
    // rr_ptr is 3 now: unit 3 must win port 1 over unit 0
    seq[0] = 5; seq[3] = 5;
    apply(4'b1001);
    tick();
    apply(4'h0);
    tick();
    compared++;
    if (got1() !== erec(3, 5)) begin
      mismatched++;
      $display("FAIL rr3_out1: got %h expected %h", got1(), erec(3, 5));
    end
    compared++;
    if (got2() !== erec(0, 5)) begin
      mismatched++;
      $display("FAIL rr3_out2: got %h expected %h", got2(), erec(0, 5));
    end
    tick();
  endtask

  task automatic test_all_units();
    logic [3:0] rdy;
    Flush = 1'b1;
    apply(4'h0);
    tick();
    Flush = 1'b0;
    for (int u = 0; u < 4; u++) seq[u] = 0;
    for (int e = 0; e < 9; e++) begin
      apply((e <= 4) ? 4'hF : 4'h0);
      #1;
      rdy = Req_Ready;
      if (e <= 4) begin
        compared++;
        if (rdy !== erdy[e]) begin
          mismatched++;
          $display("FAIL bp_ready e%0d: got %b expected %b", e, rdy, erdy[e]);
        end
      end
      tick();
      for (int u = 0; u < 4; u++) if (Req_V[u] && rdy[u]) seq[u]++;
      if (eu1[e] < 0) begin
        compared++;
        if ({Out1_valid, Out2_valid} !== 2'b00) begin
          mismatched++;
          $display("FAIL sat_idle e%0d: got %b expected 00", e, {Out1_valid, Out2_valid});
        end
      end else begin
        compared++;
        if (got1() !== erec(eu1[e], en[e])) begin
          mismatched++;
          $display("FAIL sat_out1 e%0d: got %h expected %h", e, got1(), erec(eu1[e], en[e]));
        end
        compared++;
        if (got2() !== erec(eu2[e], en[e])) begin
          mismatched++;
          $display("FAIL sat_out2 e%0d: got %h expected %h", e, got2(), erec(eu2[e], en[e]));
        end
      end
    end
    compared++;
    if (Req_Ready !== 4'b1111) begin
      mismatched++;
      $display("FAIL sat_drained_ready: got %b expected 1111", Req_Ready);
    end
  endtask

  task automatic test_flush();
    // rr_ptr = 2 at entry; build 5 buffered records and leave rr_ptr = 1
    for (int u = 0; u < 4; u++) seq[u] = 10;
    apply(4'b0111);
    tick();
    seq[0] = 11; seq[1] = 11; seq[2] = 11;
    apply(4'b1111);
    tick();
    compared++;
    if (got1() !== erec(2, 10) || got2() !== erec(0, 10)) begin
      mismatched++;
      $display("FAIL preflush_out: got %h/%h expected %h/%h", got1(), got2(), erec(2, 10), erec(0, 10));
    end
    for (int u = 0; u < 4; u++) seq[u] = seq[u] + 1;
    Flush = 1'b1;
    apply(4'b1111);
    #1;
    compared++;
    if (Req_Ready !== 4'b0000) begin
      mismatched++;
      $display("FAIL flush_ready: got %b expected 0000", Req_Ready);
    end
    tick();
    compared++;
    if ({Out1_valid, Out2_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL flush_valid: got %b expected 00", {Out1_valid, Out2_valid});
    end
    Flush = 1'b0;
    apply(4'h0);
    #1;
    compared++;
    if (Req_Ready !== 4'b1111) begin
      mismatched++;
      $display("FAIL postflush_ready: got %b expected 1111", Req_Ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if ({Out1_valid, Out2_valid} !== 2'b00) begin
        mismatched++;
        $display("FAIL postflush_idle c%0d: got %b expected 00", c, {Out1_valid, Out2_valid});
      end
    end
    // rr_ptr must be 0: unit 0 ahead of unit 3
    seq[0] = 30; seq[3] = 30;
    apply(4'b1001);
    tick();
    apply(4'h0);
    tick();
    compared++;
    if (got1() !== erec(0, 30) || got2() !== erec(3, 30)) begin
      mismatched++;
      $display("FAIL postflush_rr: got %h/%h expected %h/%h", got1(), got2(), erec(0, 30), erec(3, 30));
    end
  endtask

  task automatic test_push_pop();
    seq[1] = 40;
    for (int e = 0; e < 5; e++) begin
      apply((e < 3) ? 4'b0010 : 4'b0000);
      #1;
      compared++;
      if (Req_Ready[1] !== 1'b1) begin
        mismatched++;
        $display("FAIL pp_ready e%0d: got %b expected 1", e, Req_Ready[1]);
      end
      tick();
      if (e < 3) seq[1]++;
      if (e == 0 || e == 4) begin
        compared++;
        if (Out1_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL pp_idle e%0d: got %b expected 0", e, Out1_valid);
        end
      end else begin
        compared++;
        if (got1() !== erec(1, 39 + e) || Out2_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL pp_out e%0d: got %h v2=%b expected %h v2=0", e, got1(), Out2_valid, erec(1, 39 + e));
        end
      end
    end
  endtask

  task automatic test_reset_data();
    RST = 1'b1;
    apply(4'h0);
    tick();
    compared++;
    if (got1() !== 25'd0 || got2() !== 25'd0) begin
      mismatched++;
      $display("FAIL reset_data: got %h/%h expected 0/0", got1(), got2());
    end
    RST = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Req_V = '0; Req_Index = '0; Req_Mispred = '0; Req_NewPC = '0;
    test_reset();
    test_single();
    test_all_units();
    test_flush();
    test_push_pop();
    test_reset_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
